// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction arbiter: FSM state encoding,
// position of the R/!W bit in the address byte, and default widths.
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int RW_BIT                 = 0;
    localparam int DEF_NUM_REQ            = 4;
    localparam int DEF_ADDR_W             = 8;
    localparam int DEF_DATA_W             = 8;
    localparam int DEF_TIMEOUT_CYCLES     = 4096;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: the first asserted request at or after the pointer
// (wrapping) wins, reported both as a one-hot grant and as an index.
module rr_arbiter_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W:0]   candSum;
    logic [IDX_W-1:0] cand;

    // Scan NUM_REQ positions starting at the pointer; the sum is one bit wider so the
    // wrap works for requester counts that are not a power of two.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        candSum = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candSum = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (candSum >= (IDX_W+1)'(NUM_REQ)) begin
                candSum = candSum - (IDX_W+1)'(NUM_REQ);
            end
            cand = candSum[IDX_W-1:0];
            if (!any_o && req_i[cand]) begin
                any_o         = 1'b1;
                idx_o         = cand;
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin sharing of one I2C master engine between NUM_REQ requesters, one byte per grant.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_nack,
    output logic                      rsp_timeout,
    output logic                      m_start,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    input  logic [DATA_W-1:0]         m_rdata,
    input  logic                      m_done,
    input  logic                      m_nack
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                nack_q, nack_d;

    logic [NUM_REQ-1:0]  pickGrant;
    logic [IDX_W-1:0]    pickIdx;
    logic                pickAny;

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
`endif

    rr_arbiter_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pickGrant),
        .idx_o   (pickIdx),
        .any_o   (pickAny)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;
        req_ready = '0;
        rsp_valid = '0;
        m_start   = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    // Accept pulse is masked by rst_n so it reads 0 while reset is held.
                    req_ready = pickGrant & {NUM_REQ{rst_n}};
                    owner_d   = pickIdx;
                    addr_d    = req_addr[int'(pickIdx)*ADDR_W +: ADDR_W];
                    wdata_d   = req_wdata[int'(pickIdx)*DATA_W +: DATA_W];
                    ptr_d     = (pickIdx == IDX_W'(NUM_REQ-1)) ? '0 : pickIdx + IDX_W'(1);
                    state_d   = START;
                end
            end
            START: begin
                m_start = 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (m_done) begin
                    rdata_d = addr_q[RW_BIT] ? m_rdata : '0;
                    nack_d  = m_nack;
`ifdef I2C_ARB_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                    rdata_d   = '0;
                    nack_d    = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                state_d            = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign rsp_timeout = timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule
